// File: rtl/lfsr_share_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_share_pkg
//   Shared types and helpers for the LFSR sharing controller.
//   - state_t     : controller FSM states
//   - SEED_SUBST  : value loaded in place of an all-zero seed (lock-up guard)
//   - onehot_idx  : index of the set bit of a one-hot vector (up to 8 bits)
// ---------------------------------------------------------------------------
package lfsr_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARM,
    STEP,
    GRANT
  } state_t;

  localparam int unsigned SEED_SUBST = 1;

  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr_share_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr_i (wrapping at NUM_REQ) wins.
//   Ports:
//     req_i     in  NUM_REQ         request vector
//     ptr_i     in  clog2(NUM_REQ)  highest-priority index
//     winner_o  out clog2(NUM_REQ)  index of the winning request
//     any_req_o out 1               at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_req_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned      idx;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req_i[cand]) begin
        winner_o = cand;
        found    = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_share_ctrl
//   Shares one external LFSR core between NUM_REQ requesters. Sequences seed
//   loads and LFSR steps and hands each round-robin winner a freshly stepped
//   LFSR value.
//
//   Optional feature (macro RAND_WARMUP_EN): after every seed load the LFSR
//   is stepped WARMUP_STEPS times (WARM state) before requests are served.
//   Without the macro, LOAD returns straight to IDLE.
//
//   Ports:
//     clk        in  1        system clock, rising edge
//     rst        in  1        asynchronous reset, active low
//     seed_load  in  1        reseed request (single cycle)
//     seed       in  WIDTH    seed value, sampled with seed_load
//     req        in  NUM_REQ  level request per requester
//     gnt        out NUM_REQ  one-hot single-cycle grant
//     rnd_data   out WIDTH    random value, valid with gnt
//     rnd_valid  out 1        grant cycle indicator
//     busy       out 1        controller not idle
//     lfsr_load  out 1        load strobe to LFSR core
//     lfsr_seed  out WIDTH    seed value to LFSR core
//     lfsr_step  out 1        advance strobe to LFSR core
//     lfsr_q     in  WIDTH    LFSR core state
// ---------------------------------------------------------------------------
module lfsr_share_ctrl
  import lfsr_share_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WARMUP_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               rnd_valid,
  output logic               busy,
  output logic               lfsr_load,
  output logic [WIDTH-1:0]   lfsr_seed,
  output logic               lfsr_step,
  input  logic [WIDTH-1:0]   lfsr_q
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WARMUP_STEPS < 1 || WARMUP_STEPS > 255) begin : g_param_check
    $error("lfsr_share_ctrl: NUM_REQ or WARMUP_STEPS out of range");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [WIDTH-1:0]   seed_q;
  logic               seed_pend_q;
  logic [WIDTH-1:0]   lfsr_seed_q;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rnd_valid_q;
  logic               busy_q;
  logic               lfsr_load_q;
  logic               lfsr_step_q;

  logic [IDX_W-1:0]   arb_winner;
  logic               arb_any;
  logic [WIDTH-1:0]   seed_next;
  logic [WIDTH-1:0]   seed_fixed;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr_next;

`ifdef RAND_WARMUP_EN
  logic [7:0]         warm_cnt_q;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .winner_o (arb_winner),
    .any_req_o(arb_any)
  );

  // A seed arriving in the same IDLE cycle overrides an older pending one.
  assign seed_next  = seed_load ? seed : seed_q;
  assign seed_fixed = (seed_next == '0) ? WIDTH'(SEED_SUBST) : seed_next;

  assign gnt_idx = IDX_W'(onehot_idx(8'(gnt_q)));
  assign rr_next = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (seed_pend_q || seed_load) state_d = LOAD;
        else if (|req)                state_d = STEP;
      end
`ifdef RAND_WARMUP_EN
      LOAD:  state_d = WARM;
      WARM:  if (warm_cnt_q == 8'd1) state_d = IDLE;
`else
      LOAD:  state_d = IDLE;
      WARM:  state_d = IDLE;
`endif
      // Requests that vanish before sampling simply skip the grant.
      STEP:  state_d = arb_any ? GRANT : IDLE;
      GRANT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[arb_winner] = 1'b1;
  end

  // Strobes are registered from the next state so each one lines up
  // exactly with the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      seed_q      <= '0;
      seed_pend_q <= 1'b0;
      lfsr_seed_q <= WIDTH'(SEED_SUBST);
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lfsr_load_q <= 1'b0;
      lfsr_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= (state_d == GRANT);
      busy_q      <= (state_d != IDLE);
      lfsr_load_q <= (state_d == LOAD);
      lfsr_step_q <= (state_d == STEP) || (state_d == WARM);

      if (state_q == IDLE && state_d == LOAD) begin
        lfsr_seed_q <= seed_fixed;
        seed_pend_q <= 1'b0;
      end else if (seed_load) begin
        seed_q      <= seed;
        seed_pend_q <= 1'b1;
      end

      if (state_q == GRANT) rr_ptr_q <= rr_next;
    end
  end

`ifdef RAND_WARMUP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt_q <= '0;
    end else if (state_d == WARM) begin
      warm_cnt_q <= (state_q == LOAD) ? 8'(WARMUP_STEPS) : warm_cnt_q - 8'd1;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = busy_q;
  assign lfsr_load = lfsr_load_q;
  assign lfsr_seed = lfsr_seed_q;
  assign lfsr_step = lfsr_step_q;
  // The core only advances at the end of the STEP cycle, so the stepped
  // value is taken straight from its state register, gated by the grant.
  assign rnd_data  = rnd_valid_q ? lfsr_q : '0;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_share_ctrl
//   Bench for lfsr_share_ctrl (WIDTH=8, NUM_REQ=4, WARMUP_STEPS=16) with a
//   behavioural 8-bit LFSR core attached. Follows RAND_WARMUP_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_lfsr_share_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       busy;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic       lfsr_step;
  logic [7:0] core_q;

  int total  = 0;
  int passed = 0;

  int unsigned m_ptr  = 0;
  logic [7:0]  m_lfsr = 8'd1;

  lfsr_share_ctrl #(
    .WIDTH(8),
    .NUM_REQ(4),
    .WARMUP_STEPS(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed     (seed),
    .req      (req),
    .gnt      (gnt),
    .rnd_data (rnd_data),
    .rnd_valid(rnd_valid),
    .busy     (busy),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed),
    .lfsr_step(lfsr_step),
    .lfsr_q   (core_q)
  );

  always #5 clk = ~clk;

  // Maximal-length 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)           core_q <= 8'd1;
    else if (lfsr_load) core_q <= lfsr_seed;
    else if (lfsr_step) core_q <= lfsr_next(core_q);
  end

  function automatic int unsigned rr_pick(input int unsigned ptr, input logic [3:0] r);
    int unsigned idx;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic apply_reset();
    rst = 1'b0;
    seed_load = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    m_ptr  = 0;
    m_lfsr = 8'd1;
  endtask

  // Entered at an IDLE negedge; returns at the following IDLE negedge.
  task automatic do_grant(input logic [3:0] r);
    int unsigned pick;
    logic [3:0]  eg;
    logic [7:0]  ed;
    req = r;
    @(negedge clk);
    total++;
    if ({lfsr_step, busy, gnt, lfsr_load} !== {1'b1, 1'b1, 4'b0000, 1'b0})
      $display("FAIL step_phase: step=%b busy=%b gnt=%b load=%b, expected step=1 busy=1 gnt=0000 load=0",
               lfsr_step, busy, gnt, lfsr_load);
    else passed++;
    pick = rr_pick(m_ptr, r);
    eg   = 4'b0001 << pick;
    ed   = lfsr_next(m_lfsr);
    @(negedge clk);
    total++;
    if ({gnt, rnd_valid, rnd_data, lfsr_step} !== {eg, 1'b1, ed, 1'b0})
      $display("FAIL grant: req=%b gnt=%b valid=%b data=%h step=%b, expected gnt=%b valid=1 data=%h step=0",
               r, gnt, rnd_valid, rnd_data, lfsr_step, eg, ed);
    else passed++;
    m_lfsr = ed;
    m_ptr  = (pick + 1) % 4;
    @(negedge clk);
    req = '0;
    total++;
    if ({busy, gnt, rnd_valid, lfsr_step, lfsr_load} !== 8'h00)
      $display("FAIL idle_after_grant: busy=%b gnt=%b valid=%b step=%b load=%b, expected all 0",
               busy, gnt, rnd_valid, lfsr_step, lfsr_load);
    else passed++;
  endtask

  // Entered at the negedge inside LOAD; returns at the next IDLE negedge.
  task automatic finish_load(input logic [7:0] s);
    logic [7:0] es;
    es = (s == 8'd0) ? 8'd1 : s;
    total++;
    if ({lfsr_load, lfsr_step, busy, gnt, lfsr_seed} !== {1'b1, 1'b0, 1'b1, 4'b0000, es})
      $display("FAIL load: load=%b step=%b busy=%b gnt=%b seed=%h, expected load=1 step=0 busy=1 gnt=0000 seed=%h",
               lfsr_load, lfsr_step, busy, gnt, lfsr_seed, es);
    else passed++;
    m_lfsr = es;
    @(negedge clk);
    seed_load = 1'b0;
`ifdef RAND_WARMUP_EN
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({lfsr_step, lfsr_load, busy, gnt, rnd_valid} !== {1'b1, 1'b0, 1'b1, 4'b0000, 1'b0})
        $display("FAIL warm: cycle=%0d step=%b load=%b busy=%b gnt=%b valid=%b, expected step=1 load=0 busy=1 gnt=0000 valid=0",
                 i, lfsr_step, lfsr_load, busy, gnt, rnd_valid);
      else passed++;
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge clk);
    end
`endif
    total++;
    if ({busy, lfsr_load, lfsr_step, gnt} !== 7'd0)
      $display("FAIL load_idle: busy=%b load=%b step=%b gnt=%b, expected all 0",
               busy, lfsr_load, lfsr_step, gnt);
    else passed++;
  endtask

  task automatic do_seed(input logic [7:0] s);
    seed = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    finish_load(s);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({gnt, rnd_valid, busy, lfsr_load, lfsr_step, rnd_data, lfsr_seed} !==
          {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01})
        $display("FAIL reset: gnt=%b valid=%b busy=%b load=%b step=%b data=%h seed=%h, expected zeros and seed=01",
                 gnt, rnd_valid, busy, lfsr_load, lfsr_step, rnd_data, lfsr_seed);
      else passed++;
    end
    rst = 1'b1;
    m_ptr  = 0;
    m_lfsr = 8'd1;
    do_grant(4'b1111);
  endtask

  task automatic test_reset_midop();
    req = 4'b1111;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({gnt, rnd_valid, busy, lfsr_load, lfsr_step, lfsr_seed} !==
        {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01})
      $display("FAIL reset_async: gnt=%b valid=%b busy=%b load=%b step=%b seed=%h, expected zeros and seed=01",
               gnt, rnd_valid, busy, lfsr_load, lfsr_step, lfsr_seed);
    else passed++;
    @(negedge clk);
    total++;
    if ({gnt, rnd_valid, lfsr_step} !== 6'd0)
      $display("FAIL reset_hold: gnt=%b valid=%b step=%b, expected all 0", gnt, rnd_valid, lfsr_step);
    else passed++;
    rst = 1'b1;
    req = '0;
    m_ptr  = 0;
    m_lfsr = 8'd1;
    do_grant(4'b1111);
  endtask

  task automatic test_seed_load();
    apply_reset();
    do_seed(8'd68);
    do_grant(4'b0001);
    do_seed(8'd0);
    do_grant(4'b0001);
  endtask

  task automatic test_single();
    apply_reset();
    do_seed(8'd68);
    repeat (6) do_grant(4'b0100);
  endtask

  task automatic test_round_robin();
    apply_reset();
    repeat (12) do_grant(4'b1111);
    repeat (6) do_grant(4'b1010);
  endtask

  task automatic test_collision();
    int unsigned pick;
    logic [3:0]  eg;
    logic [7:0]  ed;
    apply_reset();
    // Two seeds arrive during STEP and GRANT; the later one is loaded.
    req = 4'b1111;
    @(negedge clk);
    seed = 8'h5A;
    seed_load = 1'b1;
    pick = rr_pick(m_ptr, 4'b1111);
    eg = 4'b0001 << pick;
    ed = lfsr_next(m_lfsr);
    @(negedge clk);
    seed = 8'hC3;
    req = '0;
    total++;
    if ({gnt, rnd_valid, rnd_data} !== {eg, 1'b1, ed})
      $display("FAIL collide_grant: gnt=%b valid=%b data=%h, expected gnt=%b valid=1 data=%h",
               gnt, rnd_valid, rnd_data, eg, ed);
    else passed++;
    m_ptr  = (pick + 1) % 4;
    @(negedge clk);
    seed_load = 1'b0;
    total++;
    if ({busy, lfsr_load, gnt} !== 6'd0)
      $display("FAIL collide_idle: busy=%b load=%b gnt=%b, expected all 0", busy, lfsr_load, gnt);
    else passed++;
    @(negedge clk);
    finish_load(8'hC3);
    do_grant(4'b1111);
    // Request and reseed together in IDLE: load runs first.
    seed = 8'h21;
    seed_load = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    seed_load = 1'b0;
    finish_load(8'h21);
    do_grant(4'b0010);
    // Reseed while LOAD is active is deferred to the next IDLE.
    seed = 8'h33;
    seed_load = 1'b1;
    @(negedge clk);
    seed = 8'h77;
    seed_load = 1'b1;
    finish_load(8'h33);
    @(negedge clk);
    finish_load(8'h77);
    do_grant(4'b1000);
  endtask

  task automatic test_random();
    apply_reset();
    repeat (40) begin
      if ($urandom_range(0, 5) == 0) do_seed(8'($urandom()));
      else                           do_grant(4'($urandom_range(1, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_seed_load();
    test_single();
    test_round_robin();
    test_collision();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
